// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue types: architectural width, default depth, fetch packet.
`include "sys_defs.svh"

package fetch_queue_pkg;

   localparam int XLEN         = `SYS_XLEN;
   localparam int FQ_DEPTH_DEF = 8;
   localparam int FQ_SLOTS     = 3;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
   } fq_pkt_t;

endpackage

// File: rtl/fq_lead_count.sv
// Counts leading ones from bit 2 down; pure combinational, no backpressure.
// Bits after the first zero are ignored so a holey packet only yields its prefix.
module fq_lead_count (
   input  logic [2:0] valids_i,
   output logic [1:0] count_o
);

   always_comb begin
      count_o = 2'd0;
      if (valids_i[2]) begin
         count_o = 2'd1;
         if (valids_i[1]) begin
            count_o = 2'd2;
            if (valids_i[0]) count_o = 2'd3;
         end
      end
   end

endmodule

// File: rtl/sys_defs.svh
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define SYS_XLEN 32
`endif

// File: rtl/fetch_queue.sv
// Circular fetch queue, 3-wide in/out; enqueue visible 1 cycle later, FWFT head window.
// fq_hold asserts when fewer than 3 free entries remain; held packets are dropped whole.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int FQ_DEPTH = FQ_DEPTH_DEF,
   parameter int FQ_WIDTH = FQ_SLOTS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [FQ_WIDTH-1:0]                fq_in_valids,
   input  logic [FQ_WIDTH-1:0][31:0]          fq_in_insts,
   input  logic [FQ_WIDTH-1:0][XLEN-1:0]      fq_in_pcs,
   input  logic                               fq_flush,
   input  logic [1:0]                         fq_dispatch_num,
   output logic                               fq_hold,
   output logic [FQ_WIDTH-1:0]                fq_out_valids,
   output logic [FQ_WIDTH-1:0][31:0]          fq_out_insts,
   output logic [FQ_WIDTH-1:0][XLEN-1:0]      fq_out_pcs,
   output logic [$clog2(FQ_DEPTH):0]          fq_count
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   fq_pkt_t       mem_q [FQ_DEPTH];

   logic [1:0] lead_num;
   logic [1:0] enq_num;
   logic [1:0] avail_num;
   logic [1:0] deq_num;

   fq_lead_count u_lead (
      .valids_i (fq_in_valids),
      .count_o  (lead_num)
   );

   // Hold depends only on registered occupancy so the icache sees a stable signal.
   always_comb begin
      fq_hold   = (CW'(FQ_DEPTH) - count_q) < CW'(3);
      enq_num   = fq_hold ? 2'd0 : lead_num;
      avail_num = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];
      deq_num   = (fq_dispatch_num > avail_num) ? avail_num : fq_dispatch_num;

      if (fq_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(deq_num);
         tail_d  = tail_q + PW'(enq_num);
         count_d = count_q + CW'(enq_num) - CW'(deq_num);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset: validity is derived entirely from count_q.
   always_ff @(posedge clk) begin
      if (!fq_flush) begin
         if (enq_num != 2'd0)
            mem_q[tail_q]          <= '{inst: fq_in_insts[2], pc: fq_in_pcs[2]};
         if (enq_num >= 2'd2)
            mem_q[tail_q + PW'(1)] <= '{inst: fq_in_insts[1], pc: fq_in_pcs[1]};
         if (enq_num == 2'd3)
            mem_q[tail_q + PW'(2)] <= '{inst: fq_in_insts[0], pc: fq_in_pcs[0]};
      end
   end

   always_comb begin
      fq_count         = count_q;
      fq_out_valids[2] = (avail_num != 2'd0);
      fq_out_valids[1] = (avail_num >= 2'd2);
      fq_out_valids[0] = (avail_num == 2'd3);

      fq_out_insts[2]  = fq_out_valids[2] ? mem_q[head_q].inst          : '0;
      fq_out_pcs[2]    = fq_out_valids[2] ? mem_q[head_q].pc            : '0;
      fq_out_insts[1]  = fq_out_valids[1] ? mem_q[head_q + PW'(1)].inst : '0;
      fq_out_pcs[1]    = fq_out_valids[1] ? mem_q[head_q + PW'(1)].pc   : '0;
      fq_out_insts[0]  = fq_out_valids[0] ? mem_q[head_q + PW'(2)].inst : '0;
      fq_out_pcs[0]    = fq_out_valids[0] ? mem_q[head_q + PW'(2)].pc   : '0;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with directed corner cases.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 8;

   logic                      clk;
   logic                      rst;
   logic [2:0]                fq_in_valids;
   logic [2:0][31:0]          fq_in_insts;
   logic [2:0][XLEN-1:0]      fq_in_pcs;
   logic                      fq_flush;
   logic [1:0]                fq_dispatch_num;
   logic                      fq_hold;
   logic [2:0]                fq_out_valids;
   logic [2:0][31:0]          fq_out_insts;
   logic [2:0][XLEN-1:0]      fq_out_pcs;
   logic [3:0]                fq_count;

   fetch_queue #(.FQ_DEPTH(DEPTH), .FQ_WIDTH(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .fq_in_valids    (fq_in_valids),
      .fq_in_insts     (fq_in_insts),
      .fq_in_pcs       (fq_in_pcs),
      .fq_flush        (fq_flush),
      .fq_dispatch_num (fq_dispatch_num),
      .fq_hold         (fq_hold),
      .fq_out_valids   (fq_out_valids),
      .fq_out_insts    (fq_out_insts),
      .fq_out_pcs      (fq_out_pcs),
      .fq_count        (fq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        checks = 0;
   int        errors = 0;
   bit        mon_en = 1'b0;
   fq_pkt_t   exp_q[$];
   fq_pkt_t   pend_q[$];
   bit        pend_flush = 1'b0;
   logic [31:0] next_pc = 32'h1000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the visible head window with the model, then retires dispatched entries.
   always @(negedge clk) begin
      if (mon_en) begin
         int sz;
         int av;
         int d;
         sz = exp_q.size();
         av = (sz > 3) ? 3 : sz;
         chk("count", 64'(fq_count), 64'(sz));
         chk("hold", 64'(fq_hold), 64'((DEPTH - sz) < 3));
         chk("out_valids", 64'(fq_out_valids), 64'({av >= 1, av >= 2, av >= 3}));
         for (int k = 0; k < 3; k++) begin
            if (k < av) begin
               chk("out_pc", 64'(fq_out_pcs[2-k]), 64'(exp_q[k].pc));
               chk("out_inst", 64'(fq_out_insts[2-k]), 64'(exp_q[k].inst));
            end else begin
               chk("idle_pc", 64'(fq_out_pcs[2-k]), 64'd0);
               chk("idle_inst", 64'(fq_out_insts[2-k]), 64'd0);
            end
         end
         d = (int'(fq_dispatch_num) > av) ? av : int'(fq_dispatch_num);
         repeat (d) void'(exp_q.pop_front());
      end
   end

   // Drive one cycle from posedge+1; the model commits after the sampling edge.
   task automatic step(input logic [2:0] v, input logic [1:0] dn, input logic fl);
      int n;
      fq_pkt_t p;
      fq_in_valids    = v;
      fq_dispatch_num = dn;
      fq_flush        = fl;
      for (int k = 2; k >= 0; k--) begin
         fq_in_pcs[k]   = next_pc;
         fq_in_insts[k] = $urandom;
         next_pc        = next_pc + 32'd4;
      end
      n = 0;
      if (v[2]) begin
         n = 1;
         if (v[1]) begin
            n = 2;
            if (v[0]) n = 3;
         end
      end
      if ((DEPTH - exp_q.size()) < 3) n = 0;
      pend_q.delete();
      for (int k = 0; k < n; k++) begin
         p.pc   = fq_in_pcs[2-k];
         p.inst = fq_in_insts[2-k];
         pend_q.push_back(p);
      end
      pend_flush = fl;
      @(posedge clk);
      #1;
      if (pend_flush) exp_q.delete();
      else foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
   endtask

   initial begin
      rst             = 1'b0;
      fq_in_valids    = '0;
      fq_in_insts     = '0;
      fq_in_pcs       = '0;
      fq_flush        = 1'b0;
      fq_dispatch_num = '0;
      #12;
      chk("rst_count", 64'(fq_count), 64'd0);
      chk("rst_valids", 64'(fq_out_valids), 64'd0);
      chk("rst_hold", 64'(fq_hold), 64'd0);
      chk("rst_pc2", 64'(fq_out_pcs[2]), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      step(3'b111, 2'd0, 1'b0);
      chk("first_count", 64'(fq_count), 64'd3);
      chk("first_valids", 64'(fq_out_valids), 64'b111);
      chk("first_pc2", 64'(fq_out_pcs[2]), 64'h1000);

      step(3'b111, 2'd0, 1'b0);
      chk("full_hold", 64'(fq_hold), 64'd1);
      step(3'b111, 2'd0, 1'b0);
      chk("held_count", 64'(fq_count), 64'd6);

      step(3'b000, 2'd3, 1'b0);
      chk("drain_count", 64'(fq_count), 64'd3);
      chk("drain_hold", 64'(fq_hold), 64'd0);
      chk("drain_pc2", 64'(fq_out_pcs[2]), 64'h100C);

      step(3'b101, 2'd0, 1'b0);
      chk("holey_count", 64'(fq_count), 64'd4);
      step(3'b011, 2'd0, 1'b0);
      chk("nolead_count", 64'(fq_count), 64'd4);

      step(3'b000, 2'd3, 1'b0);
      step(3'b000, 2'd3, 1'b0);
      for (int i = 0; i < 8; i++) step(3'b111, 2'd2, 1'b0);
      for (int i = 0; i < 4; i++) step(3'b000, 2'd3, 1'b0);
      chk("wrap_empty", 64'(fq_count), 64'd0);

      step(3'b111, 2'd0, 1'b0);
      step(3'b111, 2'd2, 1'b1);
      chk("flush_count", 64'(fq_count), 64'd0);
      chk("flush_valids", 64'(fq_out_valids), 64'd0);

      for (int i = 0; i < 1500; i++)
         step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));

      for (int i = 0; i < 3; i++) step(3'b111, 2'd1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 64'(fq_count), 64'd0);
      chk("async_rst_valids", 64'(fq_out_valids), 64'd0);
      exp_q.delete();
      fq_in_valids    = '0;
      fq_flush        = 1'b0;
      fq_dispatch_num = '0;
      #3;
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 300; i++)
         step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter FQ_DEPTH, default 8: entry count, power of two, at least 4.
REQ-002 Parameter FQ_WIDTH, default 3: superscalar width, fixed at 3 for this revision.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 fq_in_valids  in  3  per-slot fetch valids from icache; slot 2 is oldest.
REQ-006 fq_in_insts  in  3x32  fetched instruction words.
REQ-007 fq_in_pcs  in  3xSYS_XLEN  PC of each slot.
REQ-008 fq_flush  in  1  branch redirect; discard all contents.
REQ-009 fq_dispatch_num  in  2  entries consumed by decode this cycle (0-3).
REQ-010 fq_hold  out  1  backpressure to icache (drives icache_pipeline_hold).
REQ-011 fq_out_valids  out  3  head-window valids, contiguous from slot 2.
REQ-012 fq_out_insts  out  3x32  oldest three entries, oldest in slot 2.
REQ-013 fq_out_pcs  out  3xSYS_XLEN  PCs of fq_out_insts.
REQ-014 fq_count  out  log2(FQ_DEPTH)+1  current occupancy.

Function
REQ-015 Circular buffer; head, tail pointers of log2(FQ_DEPTH) bits wrap modulo FQ_DEPTH; separate count register 0..FQ_DEPTH.
REQ-016 Enqueue count = leading valids from slot 2 (patterns 000/100/110/111 -> 0/1/2/3); bits after the first 0 are ignored (e.g. 101 -> 1).
REQ-017 fq_hold = (FQ_DEPTH - fq_count) < 3, computed from the registered count only (combinational, no dependence on this cycle's dispatch).
REQ-018 When fq_hold is 1, inputs are ignored and nothing is enqueued; no partial acceptance.
REQ-019 Enqueued entries are written at tail, tail+1, tail+2 in slot order 2,1,0; visible on outputs the cycle after the write edge (1-cycle latency).
REQ-020 Outputs are first-word-fall-through from registered storage: slot 2 = head, slot 1 = head+1, slot 0 = head+2; fq_out_valids[k] set only when the entry exists.
REQ-021 Effective dequeue = min(fq_dispatch_num, number of set fq_out_valids); the excess is clamped, never underflows.
REQ-022 Same-cycle enqueue and dequeue: count_next = count + enq - deq; both pointers advance.
REQ-023 fq_flush: next cycle head = tail = 0, count = 0; flush overrides any same-cycle enqueue and dequeue.
REQ-024 Contents of invalid entries are don't-care; outputs for invalid slots are 0.

Reset
REQ-025 On rst low (asynchronous): head = 0, tail = 0, count = 0, fq_out_valids = 000, fq_hold = 0, fq_out_insts/pcs = 0.
REQ-026 Storage arrays need no reset; valid state derives solely from count.
REQ-027 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Structure
REQ-028 SYS_XLEN comes from sys_defs.svh; FQ_DEPTH default and the fetch-packet typedef (inst, pc) belong in the shared package.
REQ-029 One sub-module, fq_lead_count: combinational 3-bit leading-ones counter used for REQ-016; everything else is in fetch_queue.

Verification
REQ-030 Reset, then fq_in_valids=111 with PCs 0x1000/0x1004/0x1008 -> next cycle fq_count=3, fq_out_valids=111, fq_out_pcs[2]=0x1000.
REQ-031 Enqueue 111 with dispatch 0 for two cycles (count 6) -> fq_hold=1; inputs on the following cycle are dropped and count stays 6.
REQ-032 count=6, enqueue blocked, fq_dispatch_num=3 -> count 3, fq_hold=0, slot 2 shows the 4th-oldest PC.
REQ-033 fq_in_valids=101 -> exactly 1 entry enqueued; fq_in_valids=011 -> 0 entries.
REQ-034 Fill and drain across the wrap (12 entries through depth 8) -> PCs emerge in strict order with no loss.
REQ-035 fq_flush=1 with valids=111 and dispatch=2 in the same cycle -> next cycle count=0, fq_out_valids=000; rst low mid-stream -> count=0 before the next edge.
